// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared load-type encodings, constants and WB payload type
package wb_stage_pkg;

    localparam logic [2:0]  LT_LB     = 3'd0;
    localparam logic [2:0]  LT_LBU    = 3'd1;
    localparam logic [2:0]  LT_LH     = 3'd2;
    localparam logic [2:0]  LT_LHU    = 3'd3;
    localparam logic [2:0]  LT_LW     = 3'd4;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        we;
        logic [4:0]  waddr;
        logic        load;
        logic [2:0]  ltype;
        logic [1:0]  alow;
    } wb_payload_t;

    // Unknown load types behave as LW, so they need word alignment too.
    function automatic logic load_misaligned(input logic load, input logic [2:0] ltype,
                                             input logic [1:0] alow);
        logic half_type;
        logic byte_type;
        half_type = (ltype == LT_LH) || (ltype == LT_LHU);
        byte_type = (ltype == LT_LB) || (ltype == LT_LBU);
        if (!load || byte_type) begin
            return 1'b0;
        end
        if (half_type) begin
            return alow[0];
        end
        return alow != 2'b00;
    endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - byte/half lane select and sign/zero extension of load data
module load_ext
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  ltype,
    input  logic [1:0]  alow,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{alow, 3'b000} +: 8];
        h = alow[1] ? rdata[31:16] : rdata[15:0];
        case (ltype)
            LT_LB:   data = {{24{b[7]}}, b};
            LT_LBU:  data = {24'h00_0000, b};
            LT_LH:   data = {{16{h[15]}}, h};
            LT_LHU:  data = {16'h0000, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: one-entry holding register, load extension, RF write and trace
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_result,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_load,
    input  logic [2:0]  mem_ltype,
    input  logic [1:0]  mem_alow,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_stall,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_waddr,
    output logic [31:0] fwd_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        misalign,
    output logic [31:0] retire_cnt
);

    wb_payload_t wb_q, wb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        cap_q, cap_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic        transfer;
    logic        retire;
    logic        mis;
    logic [31:0] load_word;
    logic [31:0] ext_data;

    // The SRAM word is only valid in the load's first WB cycle; stalled cycles replay the hold copy.
    assign load_word = cap_q ? hold_q : data_sram_rdata;

    load_ext u_load_ext (
        .rdata (load_word),
        .ltype (wb_q.ltype),
        .alow  (wb_q.alow),
        .data  (ext_data)
    );

    always_comb begin
        mem_ready = !flush && (!wb_valid_q || !wb_stall);
        transfer  = mem_valid && mem_ready;
        retire    = wb_valid_q && !wb_stall && !flush;
        mis       = load_misaligned(wb_q.load, wb_q.ltype, wb_q.alow);

        wb_d       = wb_q;
        wb_valid_d = wb_valid_q;
        cap_d      = cap_q;
        hold_d     = hold_q;
        if (transfer) begin
            wb_d = '{pc: mem_pc, result: mem_result, we: mem_we, waddr: mem_waddr,
                     load: mem_load, ltype: mem_ltype, alow: mem_alow};
            wb_valid_d = 1'b1;
        end else if (flush || (wb_valid_q && !wb_stall)) begin
            wb_valid_d = 1'b0;
        end

        if (transfer || retire || flush) begin
            cap_d = 1'b0;
        end else if (wb_valid_q && wb_q.load && !cap_q) begin
            cap_d  = 1'b1;
            hold_d = data_sram_rdata;
        end

        retire_cnt_d = retire_cnt_q + {31'd0, retire};

        rf_we    = retire && wb_q.we && (wb_q.waddr != 5'd0) && !mis;
        rf_waddr = wb_q.waddr;
        rf_wdata = wb_q.load ? ext_data : wb_q.result;
        misalign = retire && mis;

        fwd_valid = rf_we;
        fwd_waddr = rf_waddr;
        fwd_wdata = rf_wdata;

        debug_wb_pc       = wb_q.pc;
        debug_wb_rf_wen   = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end

    assign retire_cnt = retire_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_q         <= '0;
            wb_valid_q   <= 1'b0;
            cap_q        <= 1'b0;
            hold_q       <= ZERO_WORD;
            retire_cnt_q <= ZERO_WORD;
        end else begin
            wb_q         <= wb_d;
            wb_valid_q   <= wb_valid_d;
            cap_q        <= cap_d;
            hold_q       <= hold_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed vectors
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic        mem_load;
    logic [2:0]  mem_ltype;
    logic [1:0]  mem_alow;
    logic [31:0] data_sram_rdata;
    logic        wb_stall;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        misalign;
    logic [31:0] retire_cnt;

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_pc            (mem_pc),
        .mem_result        (mem_result),
        .mem_we            (mem_we),
        .mem_waddr         (mem_waddr),
        .mem_load          (mem_load),
        .mem_ltype         (mem_ltype),
        .mem_alow          (mem_alow),
        .data_sram_rdata   (data_sram_rdata),
        .wb_stall          (wb_stall),
        .flush             (flush),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_waddr         (fwd_waddr),
        .fwd_wdata         (fwd_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .misalign          (misalign),
        .retire_cnt        (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit mis, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic [31:0] pc);
        exp_t e;
        e.mis = mis; e.waddr = waddr; e.wdata = wdata; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic we,
                         input logic [4:0] waddr, input logic load, input logic [2:0] ltype,
                         input logic [1:0] alow);
        mem_valid = 1'b1; mem_pc = pc; mem_result = res; mem_we = we;
        mem_waddr = waddr; mem_load = load; mem_ltype = ltype; mem_alow = alow;
        @(negedge clk);
        chk("issue_mem_ready", {31'd0, mem_ready}, 32'd1);
        sync();
        mem_valid = 1'b0;
    endtask

    // Monitor: every write or misalign pulse must match the oldest expected retire.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && (rf_we !== 1'b0 || misalign !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_retire: rf_we=%b misalign=%b waddr=%0d wdata=0x%08h expected none at %0t",
                             rf_we, misalign, rf_waddr, rf_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", debug_wb_pc, e.pc);
                    if (e.mis) begin
                        chk("mon_mis_pulse", {31'd0, misalign}, 32'd1);
                        chk("mon_mis_rf_we", {31'd0, rf_we}, 32'd0);
                    end else begin
                        chk("mon_rf_we", {31'd0, rf_we}, 32'd1);
                        chk("mon_misalign", {31'd0, misalign}, 32'd0);
                        chk("mon_rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
                        chk("mon_rf_wdata", rf_wdata, e.wdata);
                        chk("mon_fwd_valid", {31'd0, fwd_valid}, 32'd1);
                        chk("mon_fwd_waddr", {27'd0, fwd_waddr}, {27'd0, e.waddr});
                        chk("mon_fwd_wdata", fwd_wdata, e.wdata);
                        chk("mon_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
                        chk("mon_dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e.waddr});
                        chk("mon_dbg_wdata", debug_wb_rf_wdata, e.wdata);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_pc = '0; mem_result = '0; mem_we = 1'b0;
        mem_waddr = '0; mem_load = 1'b0; mem_ltype = '0; mem_alow = '0;
        data_sram_rdata = '0; wb_stall = 1'b0; flush = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        sync();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        sync();

        // ALU write: accepted at edge N, writes in cycle N+1
        push(0, 5'd5, 32'h0000_1234, 32'h0000_0100);
        issue(32'h100, 32'h1234, 1'b1, 5'd5, 1'b0, 3'd0, 2'd0);
        @(negedge clk);
        chk("alu_cnt_before", retire_cnt, 32'd0);
        sync();
        chk("alu_cnt_after", retire_cnt, 32'd1);

        // LB then LBU back to back on the same word
        push(0, 5'd6, 32'hFFFF_FF80, 32'h0000_0104);
        push(0, 5'd7, 32'h0000_0080, 32'h0000_0108);
        issue(32'h104, 32'h2003, 1'b1, 5'd6, 1'b1, 3'd0, 2'd3);
        data_sram_rdata = 32'h80FF_FF7F;
        issue(32'h108, 32'h2003, 1'b1, 5'd7, 1'b1, 3'd1, 2'd3);
        sync();
        chk("lb_lbu_cnt", retire_cnt, 32'd3);

        // LH held 3 cycles; SRAM data disappears after the first cycle
        push(0, 5'd8, 32'hFFFF_8001, 32'h0000_010C);
        issue(32'h10C, 32'h3002, 1'b1, 5'd8, 1'b1, 3'd2, 2'd2);
        data_sram_rdata = 32'h8001_0000;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rf_we", {31'd0, rf_we}, 32'd0);
            chk("stall_mem_ready", {31'd0, mem_ready}, 32'd0);
            sync();
            data_sram_rdata = 32'h0;
        end
        wb_stall = 1'b0;
        sync();
        chk("lh_cnt", retire_cnt, 32'd4);

        // LW misaligned: no write, one misalign pulse, still retires
        push(1, 5'd9, 32'h0, 32'h0000_0110);
        issue(32'h110, 32'h4001, 1'b1, 5'd9, 1'b1, 3'd4, 2'd1);
        data_sram_rdata = 32'hDEAD_BEEF;
        sync();
        chk("lw_mis_cnt", retire_cnt, 32'd5);

        // Flush with a valid WB instruction and a waiting upstream instruction
        issue(32'h114, 32'hAAAA, 1'b1, 5'd10, 1'b0, 3'd0, 2'd0);
        flush = 1'b1;
        mem_valid = 1'b1; mem_pc = 32'h118; mem_result = 32'hBBBB; mem_we = 1'b1; mem_waddr = 5'd11;
        mem_load = 1'b0;
        @(negedge clk);
        chk("flush_rf_we", {31'd0, rf_we}, 32'd0);
        chk("flush_mem_ready", {31'd0, mem_ready}, 32'd0);
        sync();
        flush = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("flush_wb_valid", {31'd0, dut.wb_valid_q}, 32'd0);
        sync();
        sync();
        chk("flush_cnt", retire_cnt, 32'd5);

        // Write to r0 is suppressed but still retires
        issue(32'h11C, 32'h7777, 1'b1, 5'd0, 1'b0, 3'd0, 2'd0);
        sync();
        chk("r0_cnt", retire_cnt, 32'd6);

        // Counter wrap
        push(0, 5'd12, 32'h0000_0055, 32'h0000_0120);
        issue(32'h120, 32'h55, 1'b1, 5'd12, 1'b0, 3'd0, 2'd0);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        sync();
        chk("wrap_cnt", retire_cnt, 32'd0);

        // Reset while an instruction is held by stall
        issue(32'h124, 32'h9999, 1'b1, 5'd13, 1'b0, 3'd0, 2'd0);
        wb_stall = 1'b1;
        @(negedge clk);
        chk("rst_stall_rf_we", {31'd0, rf_we}, 32'd0);
        sync();
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_wb_valid", {31'd0, dut.wb_valid_q}, 32'd0);
        chk("rst_mid_cnt", retire_cnt, 32'd0);
        sync();
        resetn = 1'b1;
        wb_stall = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_ready", {31'd0, mem_ready}, 32'd1);

        repeat (5) sync();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, asynchronous assert, active-low; synchronous release to clk.
REQ-003 mem_valid / mem_ready  in / out  1 / 1  upstream handshake; a transfer occurs when both are 1 on a rising edge.
REQ-004 mem_pc, mem_result, mem_we, mem_waddr, mem_load, mem_ltype, mem_alow  in  32, 32, 1, 5, 1, 3, 2
- retiring instruction's payload: PC, ALU result or load address, register-write enable, destination register, load flag, load type, and byte address bits [1:0].
REQ-005 data_sram_rdata  in  32  load data word; valid only in the first cycle a load occupies WB.
REQ-006 wb_stall  in  1  holds the WB instruction (debug/commit hold).
REQ-007 flush  in  1  kills the WB instruction and blocks acceptance.
REQ-008 rf_we, rf_waddr, rf_wdata  out  1, 5, 32  register-file write port.
REQ-009 fwd_valid, fwd_waddr, fwd_wdata  out  1, 5, 32  bypass to decode; equal to rf_* at all times.
REQ-010 debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  32, 4, 5, 32  trace port.
REQ-011 misalign  out  1  one-cycle pulse on a misaligned load retire.
REQ-012 retire_cnt  out  32  count of retired instructions.

Function
REQ-013 WB holds one instruction in a register with a valid bit wb_valid.
REQ-014 mem_ready = !flush && (!wb_valid || !wb_stall).
REQ-015 On transfer, the payload is latched and wb_valid=1. Otherwise, when wb_valid and !wb_stall, wb_valid=0.
REQ-016 Retire cycle: wb_valid && !wb_stall && !flush.
REQ-017 rf_we = retire && wb_we && (wb_waddr != 0) && !mis.
- rf_we is never asserted during stall.
- Each instruction writes exactly once.
REQ-018 Load extension, with b = byte selected by alow and h = half selected by alow[1]:
- LB: sign-extend b.
- LBU: zero-extend b.
- LH: sign-extend h.
- LHU: zero-extend h.
- LW: whole word.
REQ-019 mis = wb_load && ((LH/LHU && alow[0]) || (LW && alow != 0)). misalign = retire && mis.
REQ-020 Load-data capture:
- In the first WB cycle of a load, data_sram_rdata is captured into a hold register and a captured flag is set.
- Later cycles of the same stalled load use the hold register.
- The captured flag clears on retire, flush or a new transfer.
REQ-021 rf_wdata = extended load data if wb_load, else wb_result. rf_waddr = wb_waddr.
REQ-022 Trace port:
- debug_wb_pc = wb_pc.
- debug_wb_rf_wen = {4{rf_we}}.
- debug_wb_rf_wnum = rf_waddr.
- debug_wb_rf_wdata = rf_wdata.
REQ-023 retire_cnt increments by 1 per retire cycle, including non-writing instructions, and wraps 0xFFFFFFFF -> 0.
REQ-024 Flush:
- Forces rf_we=0 and misalign=0 in the same cycle.
- Sets wb_valid=0 on the next edge.
- Takes priority over a simultaneous mem_valid, which is not accepted.
REQ-025 Latency: an instruction accepted at edge N writes the register file in cycle N+1 absent stall or flush.

Reset
REQ-026 While resetn=0, the following are 0: wb_valid, the captured flag, hold register, retire_cnt, all payload registers, rf_we, fwd_valid, misalign and debug_wb_rf_wen.
REQ-027 Reset mid-stall discards the held instruction with no register-file write.
REQ-028 mem_ready=1 in the first cycle after release when flush=0.

Structure
REQ-029 The load-type encodings and the ZeroWord constant reside in the shared lib/defines.vh:
- LB=0, LBU=1, LH=2, LHU=3, LW=4.
- Other encodings are treated as LW.
REQ-030 The combinational aligner/extender is a sub-module named load_ext (inputs: rdata, ltype, alow; output: 32-bit data).

Verification
REQ-031 ALU op mem_we=1, waddr=5, result=0x1234 accepted at edge N -> rf_we=1, waddr=5, wdata=0x1234 in cycle N+1; retire_cnt=1.
REQ-032 LB with alow=3, rdata=0x80FF_FF7F -> wdata=0xFFFF_FF80. The same with LBU -> 0x0000_0080.
REQ-033 LH, alow=2, rdata=0x8001_0000, wb_stall held 3 cycles, rdata changed to 0 after the first cycle -> a single write of 0xFFFF_8001 after stall release; rf_we=0 during stall.
REQ-034 LW with alow=1 -> rf_we=0, misalign pulses 1 cycle, retire_cnt increments.
REQ-035 flush asserted together with a valid WB instruction and mem_valid=1 -> rf_we=0, mem_ready=0, wb_valid=0 next cycle, no later write.
REQ-036 waddr=0 with mem_we=1 -> rf_we=0. retire_cnt preset to 0xFFFFFFFF -> reads 0 after the retire.
